// File: rtl/otter_pkg.sv
// Shared types and constants for the fetch front end: NOP encoding, queue entry
// layout and the fetch-queue FSM state encoding.
package otter_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ir;
   } ifq_entry_t;

   typedef enum logic [1:0] {
      RESET_S  = 2'd0,
      RUN      = 2'd1,
      REDIRECT = 2'd2
   } ifq_state_e;

   // Sequential fetch address; 32-bit wrap is intentional.
   function automatic logic [31:0] next_fetch_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Fetch-queue storage: DEPTH entries, one write port, combinational read.
// Contents are never reset; occupancy tracking in the parent decides validity.
module ifq_fifo
   import otter_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH)
) (
   input  logic          CLK,
   input  logic          WR_EN,
   input  logic [PW-1:0] WR_PTR,
   input  ifq_entry_t    WR_DATA,
   input  logic [PW-1:0] RD_PTR,
   output ifq_entry_t    RD_DATA
);

   ifq_entry_t mem [DEPTH];

   always_ff @(posedge CLK) begin
      if (WR_EN) begin
         mem[WR_PTR] <= WR_DATA;
      end
   end

   assign RD_DATA = mem[RD_PTR];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue between the I-cache and the IF/DE register.
// Optional same-cycle bypass of an empty queue is enabled by macro IFQ_BYPASS_EN.
module inst_fetch_queue
   import otter_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   localparam int         PW       = $clog2(DEPTH),
   localparam int         CW       = PW + 1
) (
   input  logic          CLK,
   input  logic          RESET_N,
   output logic          FETCH_REQ,
   output logic [31:0]   FETCH_PC,
   input  logic          FETCH_ACK,
   input  logic [31:0]   FETCH_IR,
   output logic          DE_VALID,
   input  logic          DE_READY,
   output logic [31:0]   DE_PC,
   output logic [31:0]   DE_IR,
   input  logic          FLUSH,
   input  logic [31:0]   FLUSH_PC,
   output logic [CW-1:0] COUNT,
   output ifq_state_e    DBG_STATE
);

   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   ifq_state_e    state_q;
   logic [31:0]   pc_q;
   logic [CW-1:0] count_q;
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;

   ifq_entry_t head;
   ifq_entry_t wr_entry;
   ifq_entry_t de_entry;
   logic       not_empty;
   logic       fire;
   logic       enq;
   logic       deq;

   // Handshakes: a transfer happens only in a cycle where both sides are high
   // (FETCH_REQ&FETCH_ACK into the queue, DE_VALID&DE_READY out of it); neither
   // valid waits on its ready, and FLUSH overrides both transfers.
   assign not_empty = (count_q != '0);
   assign FETCH_REQ = (state_q == RUN) && (count_q != FULL_CNT) && !FLUSH;
   assign fire      = FETCH_REQ & FETCH_ACK;
   assign deq       = not_empty & DE_READY;
   assign wr_entry  = '{pc: pc_q, ir: FETCH_IR};

`ifdef IFQ_BYPASS_EN
   logic bypass;
   assign bypass   = fire & ~not_empty;
   // A bypassed word consumed by decode this cycle never occupies a slot.
   assign enq      = fire & ~(bypass & DE_READY);
   assign DE_VALID = not_empty | bypass;

   always_comb begin
      de_entry = '{pc: 32'h0, ir: NOP_INSTR};
      if (not_empty) begin
         de_entry = head;
      end else if (bypass) begin
         de_entry = wr_entry;
      end
   end
`else
   assign enq      = fire;
   assign DE_VALID = not_empty;

   always_comb begin
      de_entry = '{pc: 32'h0, ir: NOP_INSTR};
      if (not_empty) begin
         de_entry = head;
      end
   end
`endif

   assign DE_PC     = de_entry.pc;
   assign DE_IR     = de_entry.ir;
   assign FETCH_PC  = pc_q;
   assign COUNT     = count_q;
   assign DBG_STATE = state_q;

   ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .CLK     (CLK),
      .WR_EN   (enq),
      .WR_PTR  (wr_ptr_q),
      .WR_DATA (wr_entry),
      .RD_PTR  (rd_ptr_q),
      .RD_DATA (head)
   );

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q  <= RESET_S;
         pc_q     <= RESET_PC;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (FLUSH) begin
         state_q  <= REDIRECT;
         pc_q     <= FLUSH_PC;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         case (state_q)
            RESET_S:  state_q <= RUN;
            REDIRECT: state_q <= RUN;
            default:  state_q <= RUN;
         endcase
         if (fire) begin
            pc_q <= next_fetch_pc(pc_q);
         end
         if (enq) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (deq) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({enq, deq})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue (default build, no bypass): streaming,
// saturation, flush, PC wrap and asynchronous reset.
module tb_inst_fetch_queue;
   import otter_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        rst_b_n;
   logic        fetch_ack;
   logic [31:0] fetch_ir;
   logic        de_ready;
   logic        flush;
   logic [31:0] flush_pc;

   logic        fetch_req_a, de_valid_a;
   logic [31:0] fetch_pc_a, de_pc_a, de_ir_a;
   logic [2:0]  count_a;
   ifq_state_e  state_a;

   logic        fetch_req_b, de_valid_b;
   logic [31:0] fetch_pc_b, de_pc_b, de_ir_b;
   logic [2:0]  count_b;
   ifq_state_e  state_b;

   int n_checks = 0;
   int n_fail   = 0;

   inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut_a (
      .CLK(clk), .RESET_N(rst_n),
      .FETCH_REQ(fetch_req_a), .FETCH_PC(fetch_pc_a), .FETCH_ACK(fetch_ack), .FETCH_IR(fetch_ir),
      .DE_VALID(de_valid_a), .DE_READY(de_ready), .DE_PC(de_pc_a), .DE_IR(de_ir_a),
      .FLUSH(flush), .FLUSH_PC(flush_pc), .COUNT(count_a), .DBG_STATE(state_a)
   );

   inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_b (
      .CLK(clk), .RESET_N(rst_b_n),
      .FETCH_REQ(fetch_req_b), .FETCH_PC(fetch_pc_b), .FETCH_ACK(fetch_ack), .FETCH_IR(fetch_ir),
      .DE_VALID(de_valid_b), .DE_READY(de_ready), .DE_PC(de_pc_b), .DE_IR(de_ir_b),
      .FLUSH(flush), .FLUSH_PC(flush_pc), .COUNT(count_b), .DBG_STATE(state_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ir_of(input logic [31:0] pc);
      return 32'hC0DE_0000 ^ {pc[15:0], pc[31:16]} ^ 32'h0000_0033;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   logic [31:0] exp_pc;

   initial begin
      rst_n = 1'b0; rst_b_n = 1'b0;
      fetch_ack = 1'b0; fetch_ir = 32'h0; de_ready = 1'b0;
      flush = 1'b0; flush_pc = 32'h0;

      // Reset state
      tick(); tick();
      chk("rst_state", 32'(state_a), 32'(RESET_S));
      chk("rst_req", 32'(fetch_req_a), 32'd0);
      chk("rst_pc", fetch_pc_a, 32'h0);
      chk("rst_count", 32'(count_a), 32'd0);
      chk("rst_valid", 32'(de_valid_a), 32'd0);
      chk("rst_de_ir", de_ir_a, NOP_INSTR);
      chk("rst_de_pc", de_pc_a, 32'h0);
      rst_n = 1'b1;
      settle();
      chk("post_rst_req", 32'(fetch_req_a), 32'd0);
      tick();
      chk("run_state", 32'(state_a), 32'(RUN));
      chk("run_req", 32'(fetch_req_a), 32'd1);

      // Test 1: streaming, DE_PC lags FETCH_PC by one cycle
      fetch_ack = 1'b1; de_ready = 1'b1; fetch_ir = ir_of(32'h0);
      settle();
      chk("t1_empty_valid", 32'(de_valid_a), 32'd0);
      chk("t1_pc0", fetch_pc_a, 32'h0);
      tick();
      for (int k = 1; k <= 5; k++) begin
         fetch_ir = ir_of(32'(4 * k));
         settle();
         chk("t1_fetch_pc", fetch_pc_a, 32'(4 * k));
         chk("t1_de_valid", 32'(de_valid_a), 32'd1);
         chk("t1_de_pc", de_pc_a, 32'(4 * (k - 1)));
         chk("t1_de_ir", de_ir_a, ir_of(32'(4 * (k - 1))));
         chk("t1_count", 32'(count_a), 32'd1);
         tick();
      end

      // Redirect to 0 so saturation starts from a known PC
      flush = 1'b1; flush_pc = 32'h0; fetch_ack = 1'b0; de_ready = 1'b0;
      settle();
      chk("fl0_req", 32'(fetch_req_a), 32'd0);
      tick();
      flush = 1'b0;
      settle();
      chk("fl0_state", 32'(state_a), 32'(REDIRECT));
      chk("fl0_count", 32'(count_a), 32'd0);
      chk("fl0_req_redirect", 32'(fetch_req_a), 32'd0);
      chk("fl0_pc", fetch_pc_a, 32'h0);
      tick();

      // Test 2: saturation with DE_READY=0
      exp_pc = 32'h0;
      fetch_ack = 1'b1;
      for (int i = 0; i < 6; i++) begin
         fetch_ir = ir_of(exp_pc);
         settle();
         chk("t2_count", 32'(count_a), (i < 4) ? 32'(i) : 32'd4);
         chk("t2_req", 32'(fetch_req_a), (i < 4) ? 32'd1 : 32'd0);
         tick();
         if (i < 4) exp_pc = exp_pc + 32'd4;
      end
      chk("t2_full_count", 32'(count_a), 32'd4);
      chk("t2_full_pc", fetch_pc_a, 32'd16);

      // Test 6: full, enqueue attempt plus dequeue -> no enqueue
      de_ready = 1'b1; fetch_ir = ir_of(32'd16);
      settle();
      chk("t6_req", 32'(fetch_req_a), 32'd0);
      chk("t6_head_pc", de_pc_a, 32'h0);
      chk("t6_head_ir", de_ir_a, ir_of(32'h0));
      tick();
      chk("t6_count", 32'(count_a), 32'd3);
      chk("t6_pc", fetch_pc_a, 32'd16);

      // Drain remaining entries in order
      fetch_ack = 1'b0;
      for (int j = 1; j <= 3; j++) begin
         settle();
         chk("t2_drain_pc", de_pc_a, 32'(4 * j));
         chk("t2_drain_ir", de_ir_a, ir_of(32'(4 * j)));
         tick();
      end
      chk("t2_empty_valid", 32'(de_valid_a), 32'd0);
      chk("t2_empty_ir", de_ir_a, NOP_INSTR);

      // Test 3: COUNT=3 then FLUSH with simultaneous ACK
      de_ready = 1'b0; fetch_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         fetch_ir = ir_of(32'(16 + 4 * i));
         tick();
      end
      chk("t3_count3", 32'(count_a), 32'd3);
      flush = 1'b1; flush_pc = 32'h100; de_ready = 1'b1; fetch_ir = ir_of(32'd28);
      settle();
      chk("t3_flush_req", 32'(fetch_req_a), 32'd0);
      tick();
      flush = 1'b0; fetch_ir = ir_of(32'h100);
      settle();
      chk("t3_count0", 32'(count_a), 32'd0);
      chk("t3_req_hold", 32'(fetch_req_a), 32'd0);
      chk("t3_de_ir_nop", de_ir_a, NOP_INSTR);
      chk("t3_de_valid", 32'(de_valid_a), 32'd0);
      chk("t3_pc", fetch_pc_a, 32'h100);
      tick();
      chk("t3_req_resume", 32'(fetch_req_a), 32'd1);
      chk("t3_pc_run", fetch_pc_a, 32'h100);
      tick();
      chk("t3_de_pc", de_pc_a, 32'h100);
      chk("t3_de_ir", de_ir_a, ir_of(32'h100));
      chk("t3_next_pc", fetch_pc_a, 32'h104);

      // Test 5: COUNT=2 then asynchronous reset pulse between edges
      de_ready = 1'b0; fetch_ir = ir_of(32'h104);
      tick();
      chk("t5_count2", 32'(count_a), 32'd2);
      fetch_ack = 1'b0;
      settle();
      rst_n = 1'b0;
      settle();
      chk("t5_async_count", 32'(count_a), 32'd0);
      chk("t5_async_valid", 32'(de_valid_a), 32'd0);
      chk("t5_async_ir", de_ir_a, NOP_INSTR);
      chk("t5_async_pc", fetch_pc_a, 32'h0);
      chk("t5_async_state", 32'(state_a), 32'(RESET_S));
      rst_n = 1'b1;
      tick();
      chk("t5_release_pc", fetch_pc_a, 32'h0);
      chk("t5_release_state", 32'(state_a), 32'(RUN));

      // Test 4: PC wrap on the second instance
      rst_b_n = 1'b1; fetch_ack = 1'b1; de_ready = 1'b1;
      fetch_ir = ir_of(32'hFFFF_FFF8);
      tick();
      chk("t4_pc0", fetch_pc_b, 32'hFFFF_FFF8);
      chk("t4_req", 32'(fetch_req_b), 32'd1);
      tick();
      fetch_ir = ir_of(32'hFFFF_FFFC);
      settle();
      chk("t4_pc1", fetch_pc_b, 32'hFFFF_FFFC);
      chk("t4_de_pc1", de_pc_b, 32'hFFFF_FFF8);
      tick();
      fetch_ir = ir_of(32'h0);
      settle();
      chk("t4_pc2", fetch_pc_b, 32'h0000_0000);
      chk("t4_de_pc2", de_pc_b, 32'hFFFF_FFFC);
      chk("t4_de_ir2", de_ir_b, ir_of(32'hFFFF_FFFC));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
